// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake input path and game logic.
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef enum logic {
        StIdle = 1'b0,
        StHeld = 1'b1
    } pend_state_t;

    localparam dir_t DIR_RESET = RIGHT;

    // UP<->DOWN and LEFT<->RIGHT differ only in the low bit.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: synchronizer, hold-time debounce counter and rising-edge pulse.
module btn_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_state,
    output logic o_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_pulse;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_pulse <= 1'b0;
            // Any return to the stable level restarts the hold count.
            if (w_synced == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= w_synced;
                r_cnt    <= '0;
                r_pulse  <= w_synced;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_state = r_stable;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/snake_input_ctrl.sv
// Debounced direction buttons feeding a pending/commit direction register.
// Optional SNAKE_REVERSE_BLOCK_EN drops presses that would reverse the snake.
module snake_input_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       tick,
    output logic [1:0] dir_out,
    output logic       dir_changed,
    output logic [3:0] btn_state,
    output logic [3:0] press_pulse
);

    logic [3:0]  w_btn_raw;
    dir_t        w_cand;
    logic        w_cand_valid;
    logic        w_commit;
    logic        w_accept;
    pend_state_t r_state;
    dir_t        r_pend_dir;
    dir_t        r_dir;
    logic        r_changed;

    assign w_btn_raw = {btn_up, btn_down, btn_left, btn_right};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (w_btn_raw[g]),
            .o_state (btn_state[g]),
            .o_pulse (press_pulse[g])
        );
    end

    always_comb begin
        w_cand = RIGHT;
        if (press_pulse[3])      w_cand = UP;
        else if (press_pulse[2]) w_cand = DOWN;
        else if (press_pulse[1]) w_cand = LEFT;
    end

    assign w_cand_valid = |press_pulse;
    assign w_commit     = tick && (r_state == StHeld);

`ifdef SNAKE_REVERSE_BLOCK_EN
    dir_t w_ref_dir;
    // Compare against the direction that holds once this cycle's tick is applied.
    assign w_ref_dir = w_commit ? r_pend_dir : r_dir;
    assign w_accept  = w_cand_valid && (w_cand != opposite(w_ref_dir));
`else
    assign w_accept  = w_cand_valid;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_pend_dir <= UP;
            r_dir      <= DIR_RESET;
            r_changed  <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (w_commit) begin
                r_dir     <= r_pend_dir;
                r_changed <= (r_pend_dir != r_dir);
            end
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_pend_dir <= w_cand;
                        r_state    <= StHeld;
                    end
                end
                StHeld: begin
                    // A same-cycle press refills pending after the commit.
                    if (w_accept) begin
                        r_pend_dir <= w_cand;
                    end else if (tick) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign dir_out     = r_dir;
    assign dir_changed = r_changed;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Scoreboard bench for snake_input_ctrl with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_snake_input_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btns = 4'b0000;
    logic       tick = 1'b0;
    logic [1:0] dir_out;
    logic       dir_changed;
    logic [3:0] btn_state;
    logic [3:0] press_pulse;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] q_press[$];
    logic [1:0] q_dir[$];

    always #5 clk = ~clk;

    snake_input_ctrl #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btns[3]),
        .btn_down    (btns[2]),
        .btn_left    (btns[1]),
        .btn_right   (btns[0]),
        .tick        (tick),
        .dir_out     (dir_out),
        .dir_changed (dir_changed),
        .btn_state   (btn_state),
        .press_pulse (press_pulse)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every observed pulse / direction change must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (press_pulse != 4'b0000) begin
                if (q_press.size() == 0) check_eq("press_unexpected", press_pulse, 4'b0000);
                else check_eq("press_sb", press_pulse, q_press.pop_front());
            end
            if (dir_changed) begin
                if (q_dir.size() == 0) check_eq("dirchg_unexpected", dir_changed, 1'b0);
                else check_eq("dir_sb", dir_out, q_dir.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called and returns at posedge+1.
    task automatic press(input logic [3:0] m);
        btns = m;
        q_press.push_back(m);
        step(8);
        check_eq("held_state", btn_state, m);
        step(2);
        btns = 4'b0000;
        step(8);
        check_eq("released_state", btn_state, 4'b0000);
    endtask

    task automatic do_tick(input logic [1:0] exp_dir, input logic exp_chg);
        tick = 1'b1;
        if (exp_chg) q_dir.push_back(exp_dir);
        step(1);
        tick = 1'b0;
        @(negedge clk);
        check_eq("tick_dir", dir_out, exp_dir);
        check_eq("tick_chg", dir_changed, exp_chg);
        @(negedge clk);
        check_eq("chg_one_cycle", dir_changed, 1'b0);
        step(1);
    endtask

    initial begin
        // Reset state, no buttons
        step(3);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_eq("rst_dir", dir_out, 2'b11);
            check_eq("rst_state", btn_state, 4'b0000);
            check_eq("rst_chg", dir_changed, 1'b0);
            check_eq("rst_pulse", press_pulse, 4'b0000);
        end
        step(1);

        // Up held 10 cycles: pulse exactly 6 cycles after assertion, then tick
        btns = 4'b1000;
        q_press.push_back(4'b1000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("up_pulse_time", press_pulse, (k == 6) ? 4'b1000 : 4'b0000);
            step(1);
        end
        btns = 4'b0000;
        do_tick(2'b00, 1'b1);
        step(6);
        check_eq("up_released", btn_state, 4'b0000);

        // Down bouncing every 2 cycles never settles
        btns = 4'b0100;
        for (int k = 0; k < 24; k++) begin
            if (k > 0 && k < 20 && (k % 2) == 0) btns[2] = ~btns[2];
            if (k == 20) btns = 4'b0000;
            @(negedge clk);
            check_eq("bounce_state", btn_state[2], 1'b0);
            check_eq("bounce_pulse", press_pulse, 4'b0000);
            step(1);
        end

        // Reversal: go RIGHT, then press LEFT
        press(4'b0001);
        do_tick(2'b11, 1'b1);
        press(4'b0010);
`ifdef SNAKE_REVERSE_BLOCK_EN
        do_tick(2'b11, 1'b0);
`else
        do_tick(2'b10, 1'b1);
`endif

        // Simultaneous up+right: UP wins
        press(4'b1001);
        do_tick(2'b00, 1'b1);
        // Last press before tick wins
        press(4'b0001);
        press(4'b0010);
        do_tick(2'b10, 1'b1);
        press(4'b1000);
        press(4'b0100);
        do_tick(2'b01, 1'b1);

        // Tick and press in the same cycle: commit old pending, new press becomes pending
        press(4'b0010);
        btns = 4'b1000;
        q_press.push_back(4'b1000);
        step(6);
        tick = 1'b1;
        q_dir.push_back(2'b10);
        step(1);
        tick = 1'b0;
        @(negedge clk);
        check_eq("same_cycle_dir", dir_out, 2'b10);
        check_eq("same_cycle_chg", dir_changed, 1'b1);
        step(3);
        btns = 4'b0000;
        step(8);
        do_tick(2'b00, 1'b1);

        // Reset while pending is held: pending lost, direction back to RIGHT
        press(4'b0001);
        rst = 1'b1;
        #1;
        check_eq("async_rst_dir", dir_out, 2'b11);
        check_eq("async_rst_chg", dir_changed, 1'b0);
        check_eq("async_rst_state", btn_state, 4'b0000);
        step(3);
        rst = 1'b0;
        step(2);
        do_tick(2'b11, 1'b0);

        // Button held through reset registers after a full debounce interval
        btns = 4'b0100;
        step(2);
        rst = 1'b1;
        step(3);
        q_press.push_back(4'b0100);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("held_rst_pulse", press_pulse, (k == 6) ? 4'b0100 : 4'b0000);
            check_eq("held_rst_state", btn_state[2], (k >= 6) ? 1'b1 : 1'b0);
            step(1);
        end
        btns = 4'b0000;
        step(8);
        do_tick(2'b01, 1'b1);

        step(4);
        check_eq("press_queue_empty", q_press.size(), 0);
        check_eq("dir_queue_empty", q_dir.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
